// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl - multi-cycle FETCH/DECODE/EXEC/WB sequencer for the RV32 datapath.
//
// Fetches each instruction over a req/ack handshake to instruction memory, then
// walks it through DECODE, EXEC and WB. It gates the IR, PC and register-file
// write enables. It supports free-running (start_i level), single-step (step_i
// pulse in IDLE) and a terminal HALT on the SYSTEM opcode.
//
// Optional feature macro: SEQ_TIMEOUT_EN
//   defined   : a fetch-wait counter sends the sequencer to ERR after
//               2**TIMEOUT_W-1 un-acked FETCH cycles (2**TIMEOUT_W FETCH cycles in all)
//   undefined : FETCH waits indefinitely, err_o is tied 0
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-low reset
//   start_i     run enable (level)
//   step_i      single-step request, honoured only in IDLE
//   opcode_i    inst[6:0] from the instruction register
//   regwrite_i  RegWrite from Control
//   imem_ack_i  instruction memory data valid
//   imem_req_o  fetch request (held until ack)
//   ir_we_o     load instruction register (FETCH and ack)
//   pc_we_o     load PC with PC+4 (WB)
//   reg_we_o    register-file write enable (WB and regwrite_i)
//   busy_o      registered: in FETCH/DECODE/EXEC/WB
//   halted_o    registered: in HALT
//   err_o       registered: in ERR
//   retired_o   instructions completed through WB (wraps)
module cpu_seq_ctrl #(
  parameter int unsigned TIMEOUT_W = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [6:0]       opcode_i,
  input  logic             regwrite_i,
  input  logic             imem_ack_i,
  output logic             imem_req_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             reg_we_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic             err_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic             step_q, step_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             busy_q, halted_q, err_q;

`ifdef SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    ret_d      = ret_q;
    imem_req_o = 1'b0;
    ir_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    reg_we_o   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          step_d  = 1'b0;
        end else if (step_i) begin
          state_d = S_FETCH;
          step_d  = 1'b1;
        end
      end
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          ir_we_o = 1'b1;
          state_d = S_DECODE;
`ifdef SEQ_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
`ifdef SEQ_TIMEOUT_EN
        else if (cnt_q == '1) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DECODE: state_d = (opcode_i == OpSystem) ? S_HALT : S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB: begin
        pc_we_o  = 1'b1;
        reg_we_o = regwrite_i;
        ret_d    = ret_q + 1'b1;
        state_d  = (step_q || !start_i) ? S_IDLE : S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      step_q   <= 1'b0;
      ret_q    <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      ret_q    <= ret_d;
      // Decodes are taken from the next state so the flops track state_q exactly.
      busy_q   <= (state_d == S_FETCH) || (state_d == S_DECODE) ||
                  (state_d == S_EXEC)  || (state_d == S_WB);
      halted_q <= (state_d == S_HALT);
      err_q    <= (state_d == S_ERR);
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign busy_o    = busy_q;
  assign halted_o  = halted_q;
  assign retired_o = ret_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Randomized bench for cpu_seq_ctrl. A transaction-level model tracks whether
// the sequencer is idle, running an instruction (and how far along it is),
// halted or errored, and predicts every output each cycle.
module tb_cpu_seq_ctrl;

  localparam int unsigned TW = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0, step_i = 1'b0, regwrite_i = 1'b0, imem_ack_i = 1'b0;
  logic [6:0]  opcode_i = 7'h33;
  logic        imem_req_o, ir_we_o, pc_we_o, reg_we_o, busy_o, halted_o, err_o;
  logic [31:0] retired_o;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_seq_ctrl #(.TIMEOUT_W(TW), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .step_i(step_i),
    .opcode_i(opcode_i), .regwrite_i(regwrite_i), .imem_ack_i(imem_ack_i),
    .imem_req_o(imem_req_o), .ir_we_o(ir_we_o), .pc_we_o(pc_we_o),
    .reg_we_o(reg_we_o), .busy_o(busy_o), .halted_o(halted_o),
    .err_o(err_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: mode 0 idle, 1 running, 2 halted, 3 error.
  // While running, cyc counts cycles spent past the fetch ack (0 = still fetching).
  int          m_mode;
  int          m_cyc;
  int          m_wait;
  bit          m_single;
  logic [31:0] m_ret;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cyc = 0; m_wait = 0; m_single = 0; m_ret = '0;
  endtask

  task automatic check_all();
    bit run;
    run = (m_mode == 1);
    check("imem_req", imem_req_o, run && m_cyc == 0);
    check("ir_we",    ir_we_o,    run && m_cyc == 0 && imem_ack_i);
    check("pc_we",    pc_we_o,    run && m_cyc == 3);
    check("reg_we",   reg_we_o,   run && m_cyc == 3 && regwrite_i);
    check("busy",     busy_o,     run);
    check("halted",   halted_o,   m_mode == 2);
    check("err",      err_o,      m_mode == 3);
    check("retired",  retired_o,  m_ret);
  endtask

  task automatic model_step();
    if (m_mode == 0) begin
      if (start_i || step_i) begin
        m_mode = 1; m_cyc = 0; m_wait = 0; m_single = !start_i;
      end
    end else if (m_mode == 1) begin
      if (m_cyc == 0) begin
        if (imem_ack_i) begin
          m_cyc = 1; m_wait = 0;
        end else begin
`ifdef SEQ_TIMEOUT_EN
          if (m_wait == (1 << TW) - 1) m_mode = 3;
`endif
          m_wait++;
        end
      end else if (m_cyc == 1) begin
        if (opcode_i == 7'h73) m_mode = 2;
        else m_cyc = 2;
      end else if (m_cyc == 2) begin
        m_cyc = 3;
      end else begin
        m_ret = m_ret + 1;
        if (m_single || !start_i) m_mode = 0;
        else m_cyc = 0;
      end
    end
  endtask

  // Inputs are already driven (after a falling edge); check, advance the model, cross one rising edge.
  task automatic tick();
    #1;
    check_all();
    model_step();
    @(negedge clk_i);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    for (int i = 0; i < cycles; i++) begin
      start_i = 1'($urandom); step_i = 1'($urandom); imem_ack_i = 1'($urandom);
      regwrite_i = 1'($urandom); opcode_i = 7'($urandom);
      #1;
      check_all();
      @(negedge clk_i);
    end
    rst_i = 1'b1;
    start_i = 1'b0; step_i = 1'b0; imem_ack_i = 1'b0; opcode_i = 7'h33;
  endtask

  initial begin
    model_reset();
    // Reset hold with toggling inputs, then release to IDLE.
    do_reset(5);
    tick();
    check("idle_busy", busy_o, 1'b0);

    // Back-to-back run with immediate ack: 10 retirements after 41 edges.
    start_i = 1'b1; imem_ack_i = 1'b1; regwrite_i = 1'b1; opcode_i = 7'h33;
    for (int i = 0; i < 41; i++) tick();
    check("run10", retired_o, 32'd10);

    // Single step, ack 3 cycles after req; second step pulse while busy ignored.
    do_reset(2);
    step_i = 1'b1; tick(); step_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      imem_ack_i = (i == 3);
      step_i = (i == 5);
      tick();
    end
    step_i = 1'b0; imem_ack_i = 1'b0;
    check("step_ret", retired_o, 32'd1);
    check("step_idle", busy_o, 1'b0);

    // SYSTEM opcode halts; later start/step ignored.
    do_reset(2);
    start_i = 1'b1; imem_ack_i = 1'b1; opcode_i = 7'h73;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 10; i++) begin
      start_i = 1'($urandom); step_i = 1'($urandom); tick();
    end
    check("halt_flag", halted_o, 1'b1);
    check("halt_ret", retired_o, 32'd0);

    // No ack ever: request held, timeout behaviour depends on build.
    do_reset(2);
    start_i = 1'b1; imem_ack_i = 1'b0; opcode_i = 7'h33; step_i = 1'b0;
    for (int i = 0; i < 100; i++) tick();
`ifdef SEQ_TIMEOUT_EN
    check("timeout_err", err_o, 1'b1);
`else
    check("noto_req", imem_req_o, 1'b1);
    check("noto_err", err_o, 1'b0);
`endif

    // regwrite_i=0, drop start in EXEC, then reset mid-EXEC.
    do_reset(2);
    start_i = 1'b1; imem_ack_i = 1'b1; regwrite_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("drop_ret", retired_o, 32'd1);
    check("drop_idle", busy_o, 1'b0);
    start_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rst_i = 1'b0;
    #1;
    check("arst_busy", busy_o, 1'b0);
    check("arst_ret", retired_o, 32'd0);
    check("arst_req", imem_req_o, 1'b0);
    model_reset();
    rst_i = 1'b1; start_i = 1'b0;
    @(negedge clk_i);

    // Randomized segments with occasional resets.
    for (int seg = 0; seg < 20; seg++) begin
      int p_start, p_ack;
      p_start = $urandom_range(0, 100);
      p_ack   = $urandom_range(10, 100);
      for (int i = 0; i < 150; i++) begin
        start_i    = ($urandom_range(0, 99) < p_start);
        step_i     = ($urandom_range(0, 9) == 0);
        imem_ack_i = ($urandom_range(0, 99) < p_ack);
        regwrite_i = 1'($urandom);
        opcode_i   = ($urandom_range(0, 79) == 0) ? 7'h73 : 7'($urandom);
        if (opcode_i == 7'h73 && $urandom_range(0, 1) == 0) opcode_i = 7'h13;
        tick();
        if (m_mode >= 2 && $urandom_range(0, 9) == 0) break;
      end
      if ($urandom_range(0, 1) == 0) begin
        rst_i = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk_i);
        rst_i = 1'b1;
      end else begin
        do_reset($urandom_range(1, 3));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
